// File: rtl/hit_counter_bank_if.sv
// Control/status bundle for hit_counter_bank.
// The ovf flags exist only when HCNT_OVF_FLAG_EN is defined.
interface hit_counter_bank_if #(
  parameter int unsigned NCH = 6,
  parameter int unsigned CW  = 16,
  parameter int unsigned GW  = 24
);
  logic [NCH-1:0]    hit;
  logic              input_dis;
  logic              mode;
  logic [GW-1:0]     gate_len;
  logic              snap_tgl;
  logic              clr;
  logic [NCH*CW-1:0] hcounters;
  logic              busy;
`ifdef HCNT_OVF_FLAG_EN
  logic [NCH-1:0]    ovf;

  modport master (
    output hit, input_dis, mode, gate_len, snap_tgl, clr,
    input  hcounters, busy, ovf
  );

  modport slave (
    input  hit, input_dis, mode, gate_len, snap_tgl, clr,
    output hcounters, busy, ovf
  );
`else
  modport master (
    output hit, input_dis, mode, gate_len, snap_tgl, clr,
    input  hcounters, busy
  );

  modport slave (
    input  hit, input_dis, mode, gate_len, snap_tgl, clr,
    output hcounters, busy
  );
`endif
endinterface

// File: rtl/hit_counter_bank.sv
// Per-layer hit counter bank feeding the TAP counter snapshot (hcounters).
// Counts rising edges of each hit line, freezes a coherent snapshot either on
// a TCK-domain toggle request (manual mode) or at the end of a gate window.
// Optional feature macro: HCNT_OVF_FLAG_EN adds per-channel overflow flags.
module hit_counter_bank #(
  parameter int unsigned NCH = 6,
  parameter int unsigned CW  = 16,
  parameter int unsigned GW  = 24
) (
  input logic               clk,
  input logic               rst,
  hit_counter_bank_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GATE = 2'd2
  } state_t;

  // Update selectors handed from the FSM to the counter datapath.
  typedef enum logic [1:0] {
    L_HOLD    = 2'd0,
    L_INC     = 2'd1,
    L_ZERO    = 2'd2,
    L_RESTART = 2'd3
  } live_op_t;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_LIVE = 2'd1,
    S_INC  = 2'd2,
    S_CLR  = 2'd3
  } snap_op_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t   state, state_n;
  live_op_t live_op;
  snap_op_t snap_op;

  logic [NCH-1:0]          hit_q;
  logic [NCH-1:0]          ev;
  logic [NCH-1:0]          cnt_ev;
  logic                    s1, s2, s3;
  logic                    snap_req;
  logic [NCH-1:0][CW-1:0]  live, live_n, live_inc, live_rst;
  logic [NCH-1:0][CW-1:0]  snap, snap_n;
  logic [GW-1:0]           timer, timer_n, gate_ld;
  logic                    busy_q, busy_n;

`ifdef HCNT_OVF_FLAG_EN
  logic [NCH-1:0]          lf, lf_n, lf_inc;
  logic [NCH-1:0]          ovf_q, ovf_n;
`endif

  // Rising-edge detect and counting qualifier.
  assign ev       = bus.hit & ~hit_q;
  assign cnt_ev   = ev & {NCH{~bus.input_dis}};
  assign snap_req = s2 ^ s3;
  assign gate_ld  = (bus.gate_len == '0) ? GW'(1) : bus.gate_len;

  assign bus.hcounters = snap;
  assign bus.busy      = busy_q;
`ifdef HCNT_OVF_FLAG_EN
  assign bus.ovf       = ovf_q;
`endif

  // Hit history and snap_tgl synchroniser (TCK toggle into clk domain).
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
    end else begin
      hit_q <= bus.hit;
      s1    <= bus.snap_tgl;
      s2    <= s1;
      s3    <= s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state and datapath control; clr overrides everything.
  always_comb begin
    state_n = state;
    live_op = L_HOLD;
    snap_op = S_HOLD;
    busy_n  = busy_q;
    timer_n = timer;
    if (bus.clr) begin
      state_n = IDLE;
      live_op = L_ZERO;
      snap_op = S_CLR;
      busy_n  = 1'b0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.mode) begin
            state_n = RUN;
          end else if (snap_req) begin
            state_n = GATE;
            live_op = L_ZERO;
            busy_n  = 1'b1;
            timer_n = gate_ld;
          end
        end
        RUN: begin
          // Snapshot takes the pre-increment value; this cycle's hits seed the restart.
          if (snap_req) begin
            snap_op = S_LIVE;
          end
          if (bus.mode) begin
            state_n = IDLE;
            live_op = L_ZERO;
          end else if (snap_req) begin
            live_op = L_RESTART;
          end else begin
            live_op = L_INC;
          end
        end
        GATE: begin
          // Last window cycle still counts; snapshot includes it.
          if (timer == GW'(1)) begin
            snap_op = S_INC;
            live_op = L_ZERO;
            busy_n  = 1'b0;
            timer_n = '0;
            state_n = IDLE;
          end else begin
            live_op = L_INC;
            timer_n = timer - GW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          live_op = L_ZERO;
          busy_n  = 1'b0;
          timer_n = '0;
        end
      endcase
    end
  end

  // Saturating increment candidates and restart values per channel.
  always_comb begin
    live_inc = live;
    live_rst = '0;
`ifdef HCNT_OVF_FLAG_EN
    lf_inc   = lf;
`endif
    for (int i = 0; i < int'(NCH); i++) begin
      if (cnt_ev[i] && (live[i] != CNT_MAX)) begin
        live_inc[i] = live[i] + CW'(1);
      end
      live_rst[i] = CW'(cnt_ev[i]);
`ifdef HCNT_OVF_FLAG_EN
      lf_inc[i] = lf[i] | (cnt_ev[i] & (live[i] == CNT_MAX));
`endif
    end
  end

  // Apply the selected updates to live counters, flags and snapshot.
  always_comb begin
    live_n = live;
    snap_n = snap;
`ifdef HCNT_OVF_FLAG_EN
    lf_n   = lf;
    ovf_n  = ovf_q;
`endif
    case (live_op)
      L_INC: begin
        live_n = live_inc;
`ifdef HCNT_OVF_FLAG_EN
        lf_n   = lf_inc;
`endif
      end
      L_ZERO: begin
        live_n = '0;
`ifdef HCNT_OVF_FLAG_EN
        lf_n   = '0;
`endif
      end
      L_RESTART: begin
        live_n = live_rst;
`ifdef HCNT_OVF_FLAG_EN
        lf_n   = '0;
`endif
      end
      default: begin
        live_n = live;
      end
    endcase
    case (snap_op)
      S_LIVE: begin
        snap_n = live;
`ifdef HCNT_OVF_FLAG_EN
        ovf_n  = lf;
`endif
      end
      S_INC: begin
        snap_n = live_inc;
`ifdef HCNT_OVF_FLAG_EN
        ovf_n  = lf_inc;
`endif
      end
      S_CLR: begin
        snap_n = '0;
`ifdef HCNT_OVF_FLAG_EN
        ovf_n  = '0;
`endif
      end
      default: begin
        snap_n = snap;
      end
    endcase
  end

  // Counter, snapshot, timer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      live   <= '0;
      snap   <= '0;
      timer  <= '0;
      busy_q <= 1'b0;
`ifdef HCNT_OVF_FLAG_EN
      lf     <= '0;
      ovf_q  <= '0;
`endif
    end else begin
      live   <= live_n;
      snap   <= snap_n;
      timer  <= timer_n;
      busy_q <= busy_n;
`ifdef HCNT_OVF_FLAG_EN
      lf     <= lf_n;
      ovf_q  <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_hit_counter_bank.sv
// Directed bench for hit_counter_bank: manual snapshots from a vector table,
// gated windows, clr during a window, and saturation on a 4-bit instance.
module tb_hit_counter_bank;

  localparam int unsigned NCH = 6;
  localparam int unsigned CW  = 16;
  localparam int unsigned GW  = 24;
  localparam int unsigned SCW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hit_counter_bank_if #(.NCH(NCH), .CW(CW),  .GW(GW)) bus ();
  hit_counter_bank_if #(.NCH(NCH), .CW(SCW), .GW(GW)) sbus ();

  hit_counter_bank #(.NCH(NCH), .CW(CW), .GW(GW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hit_counter_bank #(.NCH(NCH), .CW(SCW), .GW(GW)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NCH-1:0][7:0] np;
    int                  hold_ch;
    int                  hold_len;
    int                  dis_ch;
    int                  n_dis;
    logic [95:0]         exp;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [95:0] hc6(input int c0, c1, c2, c3, c4, c5);
    return {16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [NCH-1:0][7:0] np, input int hold_ch,
                         input int hold_len, input int dis_ch, input int n_dis,
                         input logic [95:0] exp);
    vecs[k].np       = np;
    vecs[k].hold_ch  = hold_ch;
    vecs[k].hold_len = hold_len;
    vecs[k].dis_ch   = dis_ch;
    vecs[k].n_dis    = n_dis;
    vecs[k].exp      = exp;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit sat, input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sat) sbus.hit[ch] = 1'b1; else bus.hit[ch] = 1'b1;
      @(negedge clk);
      if (sat) sbus.hit[ch] = 1'b0; else bus.hit[ch] = 1'b0;
    end
  endtask

  task automatic snap(input bit sat);
    @(negedge clk);
    if (sat) sbus.snap_tgl = ~sbus.snap_tgl; else bus.snap_tgl = ~bus.snap_tgl;
    tick(4);
  endtask

  task automatic clr_pulse(input bit sat);
    @(negedge clk);
    if (sat) sbus.clr = 1'b1; else bus.clr = 1'b1;
    @(negedge clk);
    if (sat) sbus.clr = 1'b0; else bus.clr = 1'b0;
  endtask

  // Starts a window, optionally toggles hit[1] every cycle, returns busy-high cycle count.
  task automatic run_gate(input bit toggle_hit, input int extra_at, input int limit,
                          output int bcnt);
    bcnt = 0;
    @(negedge clk);
    bus.snap_tgl = ~bus.snap_tgl;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        bcnt++;
        if (bcnt == extra_at) bus.snap_tgl = ~bus.snap_tgl;
      end else if (bcnt > 0) begin
        break;
      end
      if (toggle_hit) bus.hit[1] = ~bus.hit[1];
    end
    bus.hit[1] = 1'b0;
  endtask

  initial begin
    int bcnt;
    int quiet;
    logic [95:0] tmp;

    rst            = 1'b1;
    bus.hit        = '0;
    bus.input_dis  = 1'b0;
    bus.mode       = 1'b0;
    bus.gate_len   = '0;
    bus.snap_tgl   = 1'b0;
    bus.clr        = 1'b0;
    sbus.hit       = '0;
    sbus.input_dis = 1'b0;
    sbus.mode      = 1'b0;
    sbus.gate_len  = '0;
    sbus.snap_tgl  = 1'b0;
    sbus.clr       = 1'b0;

    // ch0..ch5 packed, ch5 leftmost
    set_vec(0, {8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5}, -1, 0,  0, 0, hc6(5, 0, 0, 0, 0, 3));
    set_vec(1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},  2, 10, 0, 0, hc6(0, 0, 1, 0, 0, 0));
    set_vec(2, {8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0}, -1, 0,  3, 4, hc6(0, 0, 0, 2, 0, 0));
    set_vec(3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, -1, 0,  0, 0, hc6(0, 0, 0, 0, 0, 0));
    set_vec(4, {8'd0, 8'd7, 8'd0, 8'd0, 8'd1, 8'd0},  4, 3,  0, 0, hc6(0, 1, 0, 0, 8, 0));

    // Reset state
    tick(2);
    check("reset_hcounters", bus.hcounters, '0);
    check("reset_busy", 96'(bus.busy), '0);
    check("reset_sat_hcounters", 96'(sbus.hcounters), '0);
    rst = 1'b0;

    // No snapshot appears without a toggle, even while counting
    pulse(1'b0, 0, 3);
    tick(14);
    check("no_spurious_snap", bus.hcounters, '0);
    clr_pulse(1'b0);
    check("clr_idle_hcounters", bus.hcounters, '0);
    tick(2);

    // Manual-mode vector table
    for (int v = 0; v < 5; v++) begin
      for (int ch = 0; ch < int'(NCH); ch++) pulse(1'b0, ch, int'(vecs[v].np[ch]));
      if (vecs[v].hold_ch >= 0) begin
        @(negedge clk);
        bus.hit[vecs[v].hold_ch] = 1'b1;
        tick(vecs[v].hold_len);
        bus.hit[vecs[v].hold_ch] = 1'b0;
      end
      if (vecs[v].n_dis > 0) begin
        @(negedge clk);
        bus.input_dis = 1'b1;
        pulse(1'b0, vecs[v].dis_ch, vecs[v].n_dis);
        @(negedge clk);
        bus.input_dis = 1'b0;
      end
      snap(1'b0);
      check($sformatf("vec%0d_hcounters", v), bus.hcounters, vecs[v].exp);
      check($sformatf("vec%0d_busy", v), 96'(bus.busy), '0);
    end

    // Gated window of 100 cycles, second toggle mid-window is dropped
    @(negedge clk);
    bus.mode     = 1'b1;
    bus.gate_len = GW'(100);
    tick(3);
    run_gate(1'b1, 30, 400, bcnt);
    check("gate100_busy_cycles", 96'(bcnt), 96'd100);
    check("gate100_hcounters", bus.hcounters, hc6(0, 50, 0, 0, 0, 0));
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.busy) quiet++;
    end
    check("gate_drop_second_req", 96'(quiet), '0);
    check("gate100_hold", bus.hcounters, hc6(0, 50, 0, 0, 0, 0));

    // clr in the middle of a long window
    bus.gate_len = GW'(1000);
    @(negedge clk);
    bus.snap_tgl = ~bus.snap_tgl;
    bcnt = 0;
    for (int c = 0; c < 60 && bcnt < 50; c++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    check("long_gate_started", 96'(bcnt), 96'd50);
    clr_pulse(1'b0);
    check("clr_gate_busy", 96'(bus.busy), '0);
    check("clr_gate_hcounters", bus.hcounters, '0);
    tick(5);
    check("clr_gate_stays_idle", 96'(bus.busy), '0);

    // Fresh window after clr
    bus.gate_len = GW'(10);
    run_gate(1'b1, 0, 60, bcnt);
    check("fresh_gate_busy_cycles", 96'(bcnt), 96'd10);
    check("fresh_gate_hcounters", bus.hcounters, hc6(0, 5, 0, 0, 0, 0));

    // gate_len 0 behaves as a one-cycle window
    bus.gate_len = '0;
    tick(2);
    run_gate(1'b0, 0, 30, bcnt);
    check("gate0_busy_cycles", 96'(bcnt), 96'd1);
    check("gate0_hcounters", bus.hcounters, '0);

    // Saturation on the 4-bit instance
    pulse(1'b1, 0, 20);
    snap(1'b1);
    check("sat_hcounters", 96'(sbus.hcounters), 96'd15);
`ifdef HCNT_OVF_FLAG_EN
    check("sat_ovf", 96'(sbus.ovf), 96'd1);
`endif
    clr_pulse(1'b1);
    check("sat_clr_hcounters", 96'(sbus.hcounters), '0);
`ifdef HCNT_OVF_FLAG_EN
    check("sat_clr_ovf", 96'(sbus.ovf), '0);
`endif
    tick(2);
    pulse(1'b1, 0, 3);
    snap(1'b1);
    tmp = 96'(sbus.hcounters);
    check("sat_restart_hcounters", tmp, 96'd3);
`ifdef HCNT_OVF_FLAG_EN
    check("sat_restart_ovf", 96'(sbus.ovf), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
